pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Program-counter register and next-PC selector for the MIPS fetch stage; sits upstream of the
//  jump-target concatenation (feeds it pc_plus4[31:28]) and consumes its 32-bit jump target.
//  Selects PC+4 / branch / jump / jump-register targets each cycle, honours pipeline stall, and
//  holds a redirect that arrives during a stall until the stall releases.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  PC_STEP    4              sequential increment in bytes
// PORTS
//  clk            in   1   single clock, all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   hold PC (hazard unit); 1 = freeze
//  branch_taken   in   1   redirect to branch_target
//  branch_target  in   32  PC+4 + (sign-ext imm << 2), from ID
//  jump           in   1   redirect to jump_target (j/jal)
//  jump_target    in   32  {pc_plus4[31:28], instr_index, 2'b00} from jump-target concat
//  jr             in   1   redirect to jr_target (jr/jalr)
//  jr_target      in   32  register-file rs value
//  pc             out  32  current fetch address
//  pc_plus4       out  32  pc + PC_STEP, combinational from pc; [31:28] feeds jump concat
//  imem_req       out  1   fetch request to instruction memory
//  redirect_hold  out  1   pending-redirect buffer occupied
//  addr_err       out  1   sticky: jr_target[1:0] != 0 was accepted
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc=RESET_PC, imem_req=0, redirect_hold=0, addr_err=0, state=BOOT.
//  - FSM states: BOOT, RUN, HOLD.
//    BOOT: one cycle after reset release, imem_req=0, pc unchanged; -> RUN unconditionally.
//    RUN : imem_req=1. Redirect request r = jr|jump|branch_taken.
//          stall=0: pc <= sel_target if r, else pc_plus4.
//          stall=1 & r: latch sel_target into hold_pc, redirect_hold<=1, -> HOLD; pc unchanged.
//          stall=1 & !r: pc unchanged.
//    HOLD: imem_req=1, pc unchanged while stall=1; new redirects while in HOLD overwrite hold_pc
//          (youngest wins). stall=0: pc <= hold_pc (or new sel_target if r same cycle, it wins),
//          redirect_hold<=0, -> RUN.
//  - Priority of sel_target: jr > jump > branch_taken.
//  - Low two bits of every loaded target forced to 2'b00; pc[1:0] always 0.
//  - addr_err set when a jr redirect is accepted (latched or applied) with jr_target[1:0]!=0;
//    cleared only by rst.
//  - Arithmetic modulo 2^32: pc=32'hFFFF_FFFC -> pc_plus4=32'h0000_0000, no flag.
//  - Latency: redirect presented in cycle N with stall=0 appears on pc in cycle N+1.
//  - rst mid-HOLD discards hold_pc; rst dominates stall and all redirects.
// STRUCTURE
//  - Shared package mips_pkg: RESET_PC default, PC_STEP, FSM state localparams
//    (BOOT=2'd0, RUN=2'd1, HOLD=2'd2).
//  - One sub-module: next_pc_mux (combinational priority select + alignment mask);
//    FSM, pc and hold registers stay in pc_fetch_ctrl.
// TESTING
//  1. rst 2 cycles then release -> pc=0, imem_req=0 one cycle, then pc 0,4,8,C on successive cycles.
//  2. RUN at pc=0x100, jump=1, jump_target=0x0040_0020 -> next cycle pc=0x0040_0020.
//  3. jr=1 (0x200), jump=1 (0x300), branch_taken=1 (0x400) same cycle -> pc=0x200.
//  4. stall=1, branch_taken=1 target 0x80 for 1 cycle, stall held 3 more -> pc frozen,
//     redirect_hold=1; stall drops -> pc=0x80, redirect_hold=0.
//  5. HOLD with hold_pc=0x80, rst=1 -> pc=RESET_PC, redirect_hold=0, state BOOT.
//  6. jr_target=0x0000_1002, stall=0 -> pc=0x1000, addr_err=1 persists; pc=0xFFFF_FFFC -> pc_plus4=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: datapath width, reset/step defaults, fetch FSM states.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits are always dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: redirect requests from ID/EX and hazard unit in, fetch address out.
interface pc_fetch_ctrl_if;
  import mips_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            jr;
  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            imem_req;
  logic            redirect_hold;
  logic            addr_err;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, jr, jr_target,
    input  pc, pc_plus4, imem_req, redirect_hold, addr_err
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, jr, jr_target,
    output pc, pc_plus4, imem_req, redirect_hold, addr_err
  );

endinterface

// File: rtl/pc_fetch_ctrl_next_pc_mux.sv
// Redirect target select (jr > jump > branch) with word alignment applied to the winner.
module next_pc_mux
  import mips_pkg::*;
(
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_jr,
  input  logic [XLEN-1:0] i_jr_target,
  output logic            o_redirect_c,
  output logic [XLEN-1:0] o_target_c,
  output logic            o_jr_misaligned_c
);

  logic [XLEN-1:0] w_raw;

  always_comb begin
    w_raw = i_branch_target;
    if (i_jr)        w_raw = i_jr_target;
    else if (i_jump) w_raw = i_jump_target;
  end

  assign o_redirect_c      = i_jr | i_jump | i_branch_taken;
  assign o_target_c        = align_word(w_raw);
  assign o_jr_misaligned_c = i_jr & (i_jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// MIPS fetch-stage PC register and next-PC sequencing with stall-tolerant redirect buffer.
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  pc_fetch_ctrl_if.slave bus
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_hold_pc, w_hold_pc_nxt;
  logic            r_redirect_hold, w_redirect_hold_nxt;
  logic            r_addr_err, w_addr_err_nxt;
  logic            r_imem_req;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_jr_misaligned;
  logic [XLEN-1:0] w_pc_plus4;

  next_pc_mux u_next_pc_mux (
    .i_branch_taken    (bus.branch_taken),
    .i_branch_target   (bus.branch_target),
    .i_jump            (bus.jump),
    .i_jump_target     (bus.jump_target),
    .i_jr              (bus.jr),
    .i_jr_target       (bus.jr_target),
    .o_redirect_c      (w_redirect),
    .o_target_c        (w_target),
    .o_jr_misaligned_c (w_jr_misaligned)
  );

  assign w_pc_plus4 = r_pc + XLEN'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= BOOT;
      r_pc            <= align_word(RESET_PC);
      r_hold_pc       <= '0;
      r_redirect_hold <= 1'b0;
      r_addr_err      <= 1'b0;
      r_imem_req      <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_hold_pc       <= w_hold_pc_nxt;
      r_redirect_hold <= w_redirect_hold_nxt;
      r_addr_err      <= w_addr_err_nxt;
      r_imem_req      <= (w_state_nxt != BOOT);
    end
  end

  // Next-state and register updates; redirects are accepted only in RUN/HOLD.
  always_comb begin
    w_state_nxt         = r_state;
    w_pc_nxt            = r_pc;
    w_hold_pc_nxt       = r_hold_pc;
    w_redirect_hold_nxt = r_redirect_hold;
    w_addr_err_nxt      = r_addr_err;
    unique case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (w_jr_misaligned) w_addr_err_nxt = 1'b1;
        if (!bus.stall) begin
          w_pc_nxt = w_redirect ? w_target : w_pc_plus4;
        end else if (w_redirect) begin
          w_hold_pc_nxt       = w_target;
          w_redirect_hold_nxt = 1'b1;
          w_state_nxt         = HOLD;
        end
      end
      HOLD: begin
        if (w_jr_misaligned) w_addr_err_nxt = 1'b1;
        if (bus.stall) begin
          if (w_redirect) w_hold_pc_nxt = w_target;
        end else begin
          // A redirect arriving on the release cycle is younger than the buffered one.
          w_pc_nxt            = w_redirect ? w_target : r_hold_pc;
          w_redirect_hold_nxt = 1'b0;
          w_state_nxt         = RUN;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  assign bus.pc            = r_pc;
  assign bus.pc_plus4      = w_pc_plus4;
  assign bus.imem_req      = r_imem_req;
  assign bus.redirect_hold = r_redirect_hold;
  assign bus.addr_err      = r_addr_err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: where fetch is, whether the first post-reset cycle is still pending,
  // and the most recent redirect that arrived while stalled.
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic        m_err;

  task automatic model_edge();
    logic [31:0] tgt;
    logic        any;
    if (rst) begin
      m_pc = 32'h0; m_boot = 1'b1; m_pend = 1'b0; m_err = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      any = bus.jr | bus.jump | bus.branch_taken;
      if (bus.jr)        tgt = bus.jr_target;
      else if (bus.jump) tgt = bus.jump_target;
      else               tgt = bus.branch_target;
      tgt = tgt & ~32'd3;
      if (bus.jr && (bus.jr_target % 4 != 0)) m_err = 1'b1;
      if (bus.stall) begin
        if (any) begin m_pend = 1'b1; m_pend_pc = tgt; end
      end else begin
        if (any)         m_pc = tgt;
        else if (m_pend) m_pc = m_pend_pc;
        else             m_pc = m_pc + 32'd4;
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.jump = 1'b0;         bus.jump_target = 32'h0;
    bus.jr = 1'b0;           bus.jr_target = 32'h0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.redirect_hold !== 1'b0 || bus.addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got req=%b hold=%b err=%b exp=0,0,0", bus.imem_req, bus.redirect_hold, bus.addr_err);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.pc !== exp_pc[i] || bus.imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_pc[%0d] got pc=%h req=%b exp pc=%h req=1", i, bus.pc, bus.imem_req, exp_pc[i]);
      end
    end
  endtask

  task automatic test_jump();
    bus.jump = 1'b1; bus.jump_target = 32'h0000_0100;
    tick();
    bus.jump_target = 32'h0040_0020;
    n_checks++;
    if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL jump_setup got=%h exp=%h", bus.pc, 32'h100); end
    tick();
    drive_idle();
    n_checks++;
    if (bus.pc !== 32'h0040_0020) begin n_fail++; $display("FAIL jump_pc got=%h exp=%h", bus.pc, 32'h0040_0020); end
  endtask

  task automatic test_priority();
    bus.jr = 1'b1;           bus.jr_target = 32'h200;
    bus.jump = 1'b1;         bus.jump_target = 32'h300;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h400;
    tick();
    drive_idle();
    n_checks++;
    if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL priority_pc got=%h exp=%h", bus.pc, 32'h200); end
  endtask

  task automatic test_stall_hold();
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
    tick();
    bus.branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.pc !== 32'h200 || bus.redirect_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_frozen[%0d] got pc=%h hold=%b exp pc=%h hold=1", i, bus.pc, bus.redirect_hold, 32'h200);
      end
      if (i < 3) tick();
    end
    bus.stall = 1'b0;
    tick();
    n_checks++;
    if (bus.pc !== 32'h80 || bus.redirect_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release got pc=%h hold=%b exp pc=%h hold=0", bus.pc, bus.redirect_hold, 32'h80);
    end
  endtask

  task automatic test_hold_youngest();
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h500;
    tick();
    bus.branch_taken = 1'b0; bus.jump = 1'b1; bus.jump_target = 32'h600;
    tick();
    drive_idle();
    tick();
    n_checks++;
    if (bus.pc !== 32'h600) begin n_fail++; $display("FAIL hold_youngest got=%h exp=%h", bus.pc, 32'h600); end
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h700;
    tick();
    bus.stall = 1'b0; bus.branch_target = 32'h740;
    tick();
    drive_idle();
    n_checks++;
    if (bus.pc !== 32'h740) begin n_fail++; $display("FAIL hold_release_redirect got=%h exp=%h", bus.pc, 32'h740); end
  endtask

  task automatic test_reset_in_hold();
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    rst = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'h900;
    tick();
    n_checks++;
    if (bus.pc !== 32'h0 || bus.redirect_hold !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_hold got pc=%h hold=%b req=%b exp pc=0 hold=0 req=0", bus.pc, bus.redirect_hold, bus.imem_req);
    end
    rst = 1'b0; drive_idle();
    tick(); tick();
    n_checks++;
    if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL rst_hold_discard got=%h exp=%h", bus.pc, 32'h4); end
  endtask

  task automatic test_misalign_wrap();
    bus.jr = 1'b1; bus.jr_target = 32'h0000_1002;
    tick();
    drive_idle();
    n_checks++;
    if (bus.pc !== 32'h1000 || bus.addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL jr_misalign got pc=%h err=%b exp pc=%h err=1", bus.pc, bus.addr_err, 32'h1000);
    end
    tick(); tick();
    n_checks++;
    if (bus.pc !== 32'h1008 || bus.addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got pc=%h err=%b exp pc=%h err=1", bus.pc, bus.addr_err, 32'h1008);
    end
    bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFF;
    tick();
    drive_idle();
    n_checks++;
    if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_plus4 got pc=%h plus4=%h exp pc=fffffffc plus4=0", bus.pc, bus.pc_plus4);
    end
    tick();
    n_checks++;
    if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, 32'h0); end
  endtask

  task automatic test_random();
    int nbad = 0;
    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(0, 79) == 0);
      bus.stall        = ($urandom_range(0, 1) == 1);
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      bus.jump         = ($urandom_range(0, 7) == 0);
      bus.jr           = ($urandom_range(0, 9) == 0);
      bus.branch_target = $urandom();
      bus.jump_target   = $urandom();
      bus.jr_target     = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & ~32'd3);
      tick();
      n_checks++;
      if (bus.pc !== m_pc || bus.pc_plus4 !== m_pc + 32'd4 || bus.imem_req !== !m_boot ||
          bus.redirect_hold !== m_pend || bus.addr_err !== m_err) begin
        n_fail++;
        nbad++;
        if (nbad <= 5)
          $display("FAIL rand[%0d] got pc=%h p4=%h req=%b hold=%b err=%b exp pc=%h p4=%h req=%b hold=%b err=%b",
                   i, bus.pc, bus.pc_plus4, bus.imem_req, bus.redirect_hold, bus.addr_err,
                   m_pc, m_pc + 32'd4, !m_boot, m_pend, m_err);
      end
    end
    rst = 1'b0;
    drive_idle();
  endtask

  initial begin
    m_pc = 32'h0; m_boot = 1'b1; m_pend = 1'b0; m_pend_pc = 32'h0; m_err = 1'b0;
    drive_idle();
    test_reset();
    test_sequential();
    test_jump();
    test_priority();
    test_stall_hold();
    test_hold_youngest();
    test_reset_in_hold();
    test_misalign_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
